policy_ctrl: RTL and testbench

POLICY_CTRL -- requirements
Module: policy_ctrl

---
 rtl/ttt_pkg.sv | 25 ++
 rtl/legal_pick.sv | 27 ++
 rtl/policy_ctrl.sv | 171 +++++++++++++++++
 tb/tb_policy_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared widths, FSM states and LFSR helper for the tic-tac-toe policy block
package ttt_pkg;

  localparam int Q_W   = 18;
  localparam int N_ACT = 9;
  localparam int S_W   = 15;

  localparam logic [3:0] NO_MOVE_IDX = 4'hF;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  // Right-shift Galois taps for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DECIDE,
    ST_OUT
  } state_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/legal_pick.sv
// rtl/legal_pick.sv - first unoccupied cell at or after a start index, wrapping 8 -> 0
module legal_pick
  import ttt_pkg::*;
(
  input  logic [8:0] mask_i,
  input  logic [3:0] start_i,
  output logic [3:0] idx_o
);

  logic [4:0] pos;
  logic       found;

  always_comb begin
    idx_o = NO_MOVE_IDX;
    found = 1'b0;
    pos   = 5'd0;
    for (int i = 0; i < 9; i++) begin
      pos = 5'(start_i) + 5'(i);
      if (pos >= 5'd9) pos = pos - 5'd9;
      if (!found && !mask_i[pos]) begin
        idx_o = pos[3:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/policy_ctrl.sv
// rtl/policy_ctrl.sv - epsilon-greedy action selector over one Q-table row
module policy_ctrl #(
  parameter int Q_W   = ttt_pkg::Q_W,
  parameter int N_ACT = ttt_pkg::N_ACT,
  parameter int S_W   = ttt_pkg::S_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [S_W-1:0] state_idx,
  input  logic [8:0]     board_occ,
  input  logic           explore_en,
  input  logic [7:0]     eps_thr,
  output logic           q_rd_en,
  output logic [S_W-1:0] q_rd_state,
  output logic [3:0]     q_rd_act,
  input  logic [Q_W-1:0] q_rd_data,
  output logic           act_valid,
  input  logic           act_ready,
  output logic [3:0]     act_index,
  output logic [Q_W-1:0] act_q,
  output logic           act_explored,
  output logic           no_move,
  output logic           busy
);
  import ttt_pkg::*;

  localparam logic [3:0] LAST_ACT = 4'(N_ACT - 1);

  state_e         state_q;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [8:0]     occ_q;
  logic           exp_en_q;
  logic [7:0]     eps_q;

  logic           q_rd_en_q;
  logic [S_W-1:0] q_rd_state_q;
  logic [3:0]     q_rd_act_q;
  logic           rd_vld_q;
  logic [3:0]     rd_idx_q;

  logic [Q_W-1:0] qbuf_q [N_ACT];
  logic           best_vld_q;
  logic [3:0]     best_idx_q;
  logic [Q_W-1:0] best_val_q;

  logic           act_valid_q;
  logic [3:0]     act_index_q;
  logic [Q_W-1:0] act_q_q;
  logic           act_explored_q;
  logic           no_move_q;

  logic [3:0]     pick_start;
  logic [3:0]     pick_idx;
  logic           explore;

  assign lfsr_d     = lfsr_step(lfsr_q);
  assign pick_start = (lfsr_q[3:0] >= 4'd9) ? (lfsr_q[3:0] - 4'd9) : lfsr_q[3:0];
  assign explore    = exp_en_q && (lfsr_q < eps_q);

  legal_pick u_pick (
    .mask_i  (occ_q),
    .start_i (pick_start),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      lfsr_q         <= LFSR_SEED;
      occ_q          <= '0;
      exp_en_q       <= 1'b0;
      eps_q          <= '0;
      q_rd_en_q      <= 1'b0;
      q_rd_state_q   <= '0;
      q_rd_act_q     <= '0;
      rd_vld_q       <= 1'b0;
      rd_idx_q       <= '0;
      best_vld_q     <= 1'b0;
      best_idx_q     <= NO_MOVE_IDX;
      best_val_q     <= '0;
      act_valid_q    <= 1'b0;
      act_index_q    <= NO_MOVE_IDX;
      act_q_q        <= '0;
      act_explored_q <= 1'b0;
      no_move_q      <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      rd_vld_q <= q_rd_en_q;
      rd_idx_q <= q_rd_act_q;

      // Read data lags the strobe by one cycle; first legal value seeds the max
      if (rd_vld_q) begin
        qbuf_q[rd_idx_q] <= q_rd_data;
        if (!occ_q[rd_idx_q] &&
            (!best_vld_q || ($signed(q_rd_data) > $signed(best_val_q)))) begin
          best_vld_q <= 1'b1;
          best_idx_q <= rd_idx_q;
          best_val_q <= q_rd_data;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (board_occ == 9'h1FF) begin
              act_valid_q    <= 1'b1;
              no_move_q      <= 1'b1;
              act_index_q    <= NO_MOVE_IDX;
              act_q_q        <= '0;
              act_explored_q <= 1'b0;
              state_q        <= ST_OUT;
            end else begin
              occ_q        <= board_occ;
              exp_en_q     <= explore_en;
              eps_q        <= eps_thr;
              q_rd_state_q <= state_idx;
              q_rd_act_q   <= '0;
              q_rd_en_q    <= 1'b1;
              best_vld_q   <= 1'b0;
              state_q      <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (q_rd_act_q == LAST_ACT) begin
            q_rd_en_q <= 1'b0;
            state_q   <= ST_DRAIN;
          end else begin
            q_rd_act_q <= q_rd_act_q + 4'd1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (explore) begin
            act_index_q    <= pick_idx;
            act_q_q        <= qbuf_q[pick_idx];
            act_explored_q <= 1'b1;
          end else begin
            act_index_q    <= best_idx_q;
            act_q_q        <= best_val_q;
            act_explored_q <= 1'b0;
          end
          no_move_q   <= 1'b0;
          act_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (act_ready) begin
            act_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign q_rd_en      = q_rd_en_q;
  assign q_rd_state   = q_rd_state_q;
  assign q_rd_act     = q_rd_act_q;
  assign act_valid    = act_valid_q;
  assign act_index    = act_index_q;
  assign act_q        = act_q_q;
  assign act_explored = act_explored_q;
  assign no_move      = no_move_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_policy_ctrl.sv
// tb/tb_policy_ctrl.sv - table-driven scoreboard bench for policy_ctrl
module tb_policy_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [14:0] state_idx = '0;
  logic [8:0]  board_occ = '0;
  logic        explore_en = 1'b0;
  logic [7:0]  eps_thr = '0;
  logic        q_rd_en;
  logic [14:0] q_rd_state;
  logic [3:0]  q_rd_act;
  logic [17:0] q_rd_data = '0;
  logic        act_valid;
  logic        act_ready = 1'b1;
  logic [3:0]  act_index;
  logic [17:0] act_q;
  logic        act_explored;
  logic        no_move;
  logic        busy;

  policy_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .state_idx(state_idx),
    .board_occ(board_occ), .explore_en(explore_en), .eps_thr(eps_thr),
    .q_rd_en(q_rd_en), .q_rd_state(q_rd_state), .q_rd_act(q_rd_act),
    .q_rd_data(q_rd_data), .act_valid(act_valid), .act_ready(act_ready),
    .act_index(act_index), .act_q(act_q), .act_explored(act_explored),
    .no_move(no_move), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]        occ;
    logic [8:0][17:0]  q;
    logic              en;
    logic [7:0]        eps;
    logic [3:0]        idx;
    logic [17:0]       qv;
    logic              nm;
  } vec_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [17:0] q;
    logic        expl;
    logic        nm;
    logic [7:0]  lat;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  vec_t        tbl[7];
  logic [17:0] qmem[9];
  logic [7:0]  lfsr_m;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Q-table memory with one-cycle read latency; garbage when not strobed
  always @(posedge clk) begin
    q_rd_data <= q_rd_en ? qmem[q_rd_act] : 18'($urandom);
    lfsr_m    <= rst ? 8'hA5 : lfsr_adv(lfsr_m);
  end

  function automatic logic [8:0][17:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [8:0][17:0] r;
    r[0] = 18'(a0); r[1] = 18'(a1); r[2] = 18'(a2);
    r[3] = 18'(a3); r[4] = 18'(a4); r[5] = 18'(a5);
    r[6] = 18'(a6); r[7] = 18'(a7); r[8] = 18'(a8);
    return r;
  endfunction

  function automatic exp_t row_exp(input vec_t v);
    exp_t e;
    e.idx  = v.idx;
    e.q    = v.qv;
    e.expl = 1'b0;
    e.nm   = v.nm;
    e.lat  = v.nm ? 8'd1 : 8'd12;
    return e;
  endfunction

  function automatic exp_t predict(input vec_t v, input logic [7:0] l);
    exp_t e;
    int   s, p, best;
    e.nm  = 1'b0;
    e.lat = 8'd12;
    if (v.en && (l < v.eps)) begin
      s = int'(l[3:0]);
      if (s >= 9) s -= 9;
      e.idx = 4'hF;
      for (int i = 0; i < 9; i++) begin
        p = (s + i) % 9;
        if (!v.occ[p] && e.idx == 4'hF) e.idx = 4'(p);
      end
      e.q    = v.q[e.idx];
      e.expl = 1'b1;
    end else begin
      best = -1;
      for (int i = 0; i < 9; i++)
        if (!v.occ[i] && (best < 0 || $signed(v.q[i]) > $signed(v.q[best]))) best = i;
      e.idx  = 4'(best);
      e.q    = v.q[best];
      e.expl = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("act_index", 32'(act_index), 32'(e.idx));
      check("act_q", 32'(act_q), 32'(e.q));
      check("act_explored", 32'(act_explored), 32'(e.expl));
      check("no_move", 32'(no_move), 32'(e.nm));
    end
  endtask

  task automatic drive(input vec_t v, output logic [14:0] sidx);
    for (int k = 0; k < 9; k++) qmem[k] = v.q[k];
    sidx       = 15'($urandom);
    state_idx  = sidx;
    board_occ  = v.occ;
    explore_en = v.en;
    eps_thr    = v.eps;
    start      = 1'b1;
  endtask

  // Called at a negedge; that cycle is cycle 0 of the request
  task automatic run_vec(input vec_t v, input exp_t e);
    logic [14:0] sidx;
    int          cyc, reads, rd_err;
    bit          got;
    sb.push_back(e);
    drive(v, sidx);
    cyc = 0; reads = 0; rd_err = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (q_rd_en) begin
        if (q_rd_act !== 4'(cyc - 1) || q_rd_state !== sidx || cyc > 9) rd_err++;
        reads++;
      end
      if (act_valid) got = 1;
    end
    check("rd_count", 32'(reads), e.nm ? 32'd0 : 32'd9);
    check("rd_addr", 32'(rd_err), 32'd0);
    if (!got) begin
      check("act_valid_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      check("latency", 32'(cyc), 32'(e.lat));
      compare_out();
    end
    @(negedge clk);
    check("idle_after", {30'd0, busy, act_valid}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    exp_t        e;
    logic [7:0]  l;
    logic [14:0] sidx;
    int          cyc;
    bit          got, seen;

    tbl[0] = '{occ: 9'h000, q: mk9(10, 10, 10, 100, 10, 10, 10, 10, 10), en: 1'b0, eps: 8'h00, idx: 4'd3, qv: 18'd100, nm: 1'b0};
    tbl[1] = '{occ: 9'h000, q: mk9(0, 0, 50, 0, 0, 0, 50, 0, 0), en: 1'b0, eps: 8'h00, idx: 4'd2, qv: 18'd50, nm: 1'b0};
    tbl[2] = '{occ: 9'h001, q: mk9(200, 0, 0, 0, 0, 0, 0, 150, 0), en: 1'b0, eps: 8'h00, idx: 4'd7, qv: 18'd150, nm: 1'b0};
    tbl[3] = '{occ: 9'h000, q: mk9(-5, -5, -5, -5, -5, -5, -5, -5, -1), en: 1'b0, eps: 8'h00, idx: 4'd8, qv: 18'h3FFFF, nm: 1'b0};
    tbl[4] = '{occ: 9'h1FF, q: mk9(1, 2, 3, 4, 5, 6, 7, 8, 9), en: 1'b1, eps: 8'hFF, idx: 4'hF, qv: 18'd0, nm: 1'b1};
    tbl[5] = '{occ: 9'h1EF, q: mk9(131071, 131071, 131071, 131071, -131072, 131071, 131071, 131071, 131071),
               en: 1'b0, eps: 8'h00, idx: 4'd4, qv: 18'h20000, nm: 1'b0};
    tbl[6] = '{occ: 9'h000, q: mk9(7, 3, 9, -2, 0, 1, 8, 9, 4), en: 1'b1, eps: 8'h00, idx: 4'd2, qv: 18'd9, nm: 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_q_rd_en", 32'(q_rd_en), 32'd0);
    check("rst_act_valid", 32'(act_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_move", 32'(no_move), 32'd0);
    check("rst_explored", 32'(act_explored), 32'd0);
    check("rst_act_index", 32'(act_index), 32'hF);
    check("rst_act_q", 32'(act_q), 32'd0);
    check("rst_rd_addr", {13'd0, q_rd_state, q_rd_act}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], row_exp(tbl[i]));

    // Exploration path, predicted from the LFSR value in the decide cycle
    v = '{occ: 9'h0C3, q: mk9(11, 22, -33, 44, 55, -66, 77, 88, 99), en: 1'b1, eps: 8'hFF, idx: 4'd0, qv: 18'd0, nm: 1'b0};
    for (int g = 0; g < 3; g++) begin
      repeat (g * 3 + 1) @(negedge clk);
      l = lfsr_m;
      repeat (11) l = lfsr_adv(l);
      run_vec(v, predict(v, l));
    end

    // Backpressure: outputs hold while act_ready is low, start ignored throughout
    act_ready = 1'b0;
    e = row_exp(tbl[0]);
    sb.push_back(e);
    drive(tbl[0], sidx);
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (act_valid) got = 1;
    end
    check("stall_latency", 32'(cyc), 32'd12);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      @(negedge clk);
      check("stall_hold", {8'd0, act_valid, act_index, act_q, act_explored},
                          {8'd0, 1'b1, e.idx, e.q, 1'b0});
    end
    act_ready = 1'b1;
    compare_out();
    @(negedge clk);
    start = 1'b0;
    check("stall_release", {30'd0, busy, act_valid}, 32'd0);
    @(negedge clk);
    check("start_in_handshake_ignored", 32'(busy), 32'd0);

    // Reset in cycle 5 of a request abandons it
    drive(tbl[1], sidx);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_q_rd_en", 32'(q_rd_en), 32'd0);
    check("midrst_busy", {30'd0, busy, act_valid}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (act_valid || q_rd_en) seen = 1;
    end
    check("midrst_no_activity", 32'(seen), 32'd0);

    l = lfsr_m;
    repeat (11) l = lfsr_adv(l);
    run_vec(v, predict(v, l));
    run_vec(tbl[2], row_exp(tbl[2]));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
